sram_arbiter: RTL and testbench

//  Shares the single 512Kx8 asynchronous SRAM between three requesters on the 28 MHz

---
 rtl/sram_arbiter.sv | 158 +++++++++++++++
 tb/tb_sram_arbiter.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_arbiter.sv
// Arbiter sharing one asynchronous 512Kx8 SRAM between video fetch, CPU and boot loader.
// Video has absolute priority; CPU and loader alternate through a round-robin pointer.
// Each access occupies ACCESS_CYCLES clocks in ACCESS, then one ACK clock that pulses the
// granted port's ack and can immediately grant the next pending requester.
module sram_arbiter #(
  parameter int ACCESS_CYCLES = 2,
  parameter int AW            = 19
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          vid_req,
  input  logic [AW-1:0] vid_addr,
  output logic          vid_ack,
  output logic [7:0]    vid_rdata,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [7:0]    cpu_wdata,
  output logic          cpu_ack,
  output logic [7:0]    cpu_rdata,
  input  logic          ldr_req,
  input  logic          ldr_we,
  input  logic [AW-1:0] ldr_addr,
  input  logic [7:0]    ldr_wdata,
  output logic          ldr_ack,
  output logic [7:0]    ldr_rdata,
  output logic [AW-1:0] sram_addr,
  output logic [7:0]    sram_dout,
  input  logic [7:0]    sram_din,
  output logic          sram_oe,
  output logic          sram_we_n
);

  typedef enum logic [1:0] {IDLE, ACCESS, ACK} state_t;
  typedef enum logic [1:0] {P_VID, P_CPU, P_LDR} port_t;

  localparam logic [3:0] CNT_LOAD = 4'(ACCESS_CYCLES - 1);

  state_t        state, state_nx;
  port_t         gnt, gnt_nx, grant_port;
  logic [3:0]    cnt, cnt_nx;
  logic          wr, wr_nx;
  logic          rr_cpu;
  logic          avail_vid, avail_cpu, avail_ldr;
  logic          grant_go, grant_we, take;
  logic [AW-1:0] grant_addr;
  logic [7:0]    grant_wdata;
  logic          we_n_nx, oe_nx, rd_done;

  // Pick the next port: video first, then CPU/loader by rr_cpu; the port just acked sits out.
  always_comb begin
    avail_vid   = vid_req && !(state == ACK && gnt == P_VID);
    avail_cpu   = cpu_req && !(state == ACK && gnt == P_CPU);
    avail_ldr   = ldr_req && !(state == ACK && gnt == P_LDR);
    grant_go    = 1'b0;
    grant_port  = P_VID;
    grant_we    = 1'b0;
    grant_addr  = vid_addr;
    grant_wdata = sram_dout;
    if (avail_vid) begin
      grant_go   = 1'b1;
      grant_port = P_VID;
    end else if (avail_cpu && (rr_cpu || !avail_ldr)) begin
      grant_go    = 1'b1;
      grant_port  = P_CPU;
      grant_we    = cpu_we;
      grant_addr  = cpu_addr;
      grant_wdata = cpu_wdata;
    end else if (avail_ldr) begin
      grant_go    = 1'b1;
      grant_port  = P_LDR;
      grant_we    = ldr_we;
      grant_addr  = ldr_addr;
      grant_wdata = ldr_wdata;
    end
  end

  // Next-state logic; strobes are derived from the next state so the pins come straight from flops.
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    gnt_nx   = gnt;
    wr_nx    = wr;
    take     = 1'b0;
    case (state)
      IDLE, ACK: begin
        if (grant_go) begin
          state_nx = ACCESS;
          cnt_nx   = CNT_LOAD;
          gnt_nx   = grant_port;
          wr_nx    = grant_we;
          take     = 1'b1;
        end else begin
          state_nx = IDLE;
        end
      end
      ACCESS: begin
        if (cnt == 4'd0) state_nx = ACK;
        else             cnt_nx   = cnt - 4'd1;
      end
      default: state_nx = IDLE;
    endcase
    // Write strobe releases one cycle before the end of the access so address/data hold past it.
    we_n_nx = !(state_nx == ACCESS && wr_nx && cnt_nx != 4'd0);
    oe_nx   = (state_nx == ACCESS) && wr_nx;
  end

  assign rd_done = (state == ACCESS) && (cnt == 4'd0) && !wr;
  assign vid_ack = (state == ACK) && (gnt == P_VID);
  assign cpu_ack = (state == ACK) && (gnt == P_CPU);
  assign ldr_ack = (state == ACK) && (gnt == P_LDR);

  // Control registers: FSM state, access counter, grant, round-robin pointer, pin strobes.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= 4'd0;
      gnt       <= P_VID;
      wr        <= 1'b0;
      rr_cpu    <= 1'b1;
      sram_we_n <= 1'b1;
      sram_oe   <= 1'b0;
    end else begin
      state     <= state_nx;
      cnt       <= cnt_nx;
      gnt       <= gnt_nx;
      wr        <= wr_nx;
      sram_we_n <= we_n_nx;
      sram_oe   <= oe_nx;
      if (take && grant_port == P_CPU) rr_cpu <= 1'b0;
      if (take && grant_port == P_LDR) rr_cpu <= 1'b1;
    end
  end

  // Datapath registers: latched address/write data and per-port read data.
  always_ff @(posedge clk) begin
    if (rst) begin
      sram_addr <= '0;
      sram_dout <= 8'd0;
      vid_rdata <= 8'd0;
      cpu_rdata <= 8'd0;
      ldr_rdata <= 8'd0;
    end else begin
      if (take) begin
        sram_addr <= grant_addr;
        sram_dout <= grant_wdata;
      end
      if (rd_done) begin
        case (gnt)
          P_VID:   vid_rdata <= sram_din;
          P_CPU:   cpu_rdata <= sram_din;
          default: ldr_rdata <= sram_din;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_sram_arbiter.sv
// Testbench for sram_arbiter: SRAM device model, per-port expectation queues fed by the
// request drivers, and a negedge monitor that pops and checks on every ack.
module tb_sram_arbiter;
  localparam int AW = 19;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic          vid_req, vid_ack, cpu_req, cpu_we, cpu_ack, ldr_req, ldr_we, ldr_ack;
  logic [AW-1:0] vid_addr, cpu_addr, ldr_addr, sram_addr;
  logic [7:0]    vid_rdata, cpu_rdata, cpu_wdata, ldr_rdata, ldr_wdata, sram_dout, sram_din;
  logic          sram_oe, sram_we_n;

  logic          vid_req4, vid_ack4, cpu_req4, cpu_we4, cpu_ack4, ldr_req4, ldr_we4, ldr_ack4;
  logic [AW-1:0] vid_addr4, cpu_addr4, ldr_addr4, sram_addr4;
  logic [7:0]    vid_rdata4, cpu_rdata4, cpu_wdata4, ldr_rdata4, ldr_wdata4, sram_dout4, sram_din4;
  logic          sram_oe4, sram_we_n4;

  sram_arbiter #(.ACCESS_CYCLES(2), .AW(AW)) dut (
    .clk(clk), .rst(rst),
    .vid_req(vid_req), .vid_addr(vid_addr), .vid_ack(vid_ack), .vid_rdata(vid_rdata),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
    .ldr_req(ldr_req), .ldr_we(ldr_we), .ldr_addr(ldr_addr), .ldr_wdata(ldr_wdata),
    .ldr_ack(ldr_ack), .ldr_rdata(ldr_rdata),
    .sram_addr(sram_addr), .sram_dout(sram_dout), .sram_din(sram_din),
    .sram_oe(sram_oe), .sram_we_n(sram_we_n)
  );

  sram_arbiter #(.ACCESS_CYCLES(4), .AW(AW)) dut4 (
    .clk(clk), .rst(rst),
    .vid_req(vid_req4), .vid_addr(vid_addr4), .vid_ack(vid_ack4), .vid_rdata(vid_rdata4),
    .cpu_req(cpu_req4), .cpu_we(cpu_we4), .cpu_addr(cpu_addr4), .cpu_wdata(cpu_wdata4),
    .cpu_ack(cpu_ack4), .cpu_rdata(cpu_rdata4),
    .ldr_req(ldr_req4), .ldr_we(ldr_we4), .ldr_addr(ldr_addr4), .ldr_wdata(ldr_wdata4),
    .ldr_ack(ldr_ack4), .ldr_rdata(ldr_rdata4),
    .sram_addr(sram_addr4), .sram_dout(sram_dout4), .sram_din(sram_din4),
    .sram_oe(sram_oe4), .sram_we_n(sram_we_n4)
  );

  // Asynchronous SRAM device: reads follow the address, writes land while we_n is low.
  logic [7:0] mem [0:(1<<AW)-1];
  assign sram_din = mem[sram_addr];
  always @(posedge clk) if (!sram_we_n) mem[sram_addr] <= sram_dout;

  function automatic logic [7:0] init_val(input logic [AW-1:0] a);
    return a[7:0] ^ a[15:8] ^ {5'd0, a[18:16]};
  endfunction

  initial for (int i = 0; i < (1 << AW); i++) mem[i] <= init_val(AW'(i));

  // Reference memory: contents as the requesters' completed writes define them.
  logic [7:0] ref_mem [int];
  function automatic logic [7:0] ref_read(input logic [AW-1:0] a);
    if (ref_mem.exists(int'(a))) return ref_mem[int'(a)];
    return init_val(a);
  endfunction

  int tests = 0;
  int fails = 0;
  function automatic void check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endfunction

  // Expectations per port: {is_write, read_data}.
  logic [8:0] exp_vid[$], exp_cpu[$], exp_ldr[$];
  logic [7:0] last_rd [0:2];
  int         ack_log[$];

  function automatic logic ack_of(input int p);
    case (p)
      0:       return vid_ack;
      1:       return cpu_ack;
      default: return ldr_ack;
    endcase
  endfunction

  function automatic void mon_port(input int p, input logic [7:0] rd);
    logic [8:0] e;
    logic       have;
    have = 1'b0;
    e    = 9'd0;
    case (p)
      0: if (exp_vid.size() > 0) begin e = exp_vid.pop_front(); have = 1'b1; end
      1: if (exp_cpu.size() > 0) begin e = exp_cpu.pop_front(); have = 1'b1; end
      default: if (exp_ldr.size() > 0) begin e = exp_ldr.pop_front(); have = 1'b1; end
    endcase
    ack_log.push_back(p);
    if (!have) begin
      tests++;
      fails++;
      $display("FAIL unexpected_ack: port %0d acked with no request outstanding, expected no ack", p);
    end else if (!e[8]) begin
      check($sformatf("rdata_port%0d", p), rd, e[7:0]);
      last_rd[p] = e[7:0];
    end else begin
      check($sformatf("write_keeps_rdata_port%0d", p), rd, last_rd[p]);
    end
  endfunction

  // Monitor: on every ack pop the port's expectation; also one-hot acks and strobe sanity.
  always @(negedge clk) begin
    int nacks;
    if (rst) begin
      exp_vid.delete();
      exp_cpu.delete();
      exp_ldr.delete();
      for (int i = 0; i < 3; i++) last_rd[i] = 8'd0;
    end else begin
      nacks = int'(vid_ack) + int'(cpu_ack) + int'(ldr_ack);
      if (nacks != 0) check("single_ack", nacks, 1);
      if (!sram_we_n) check("we_low_needs_oe", sram_oe, 1);
      if (vid_ack) mon_port(0, vid_rdata);
      if (cpu_ack) mon_port(1, cpu_rdata);
      if (ldr_ack) mon_port(2, ldr_rdata);
    end
  end

  // Issue one access on port p (0 vid, 1 cpu, 2 ldr); lat = clocks from req to ack.
  task automatic access(input int p, input logic we, input logic [AW-1:0] a,
                        input logic [7:0] wd, output int lat, output int welow);
    logic [8:0] e;
    logic       got;
    if (p != 0 && we) begin
      ref_mem[int'(a)] = wd;
      e = {1'b1, 8'h00};
    end else begin
      e = {1'b0, ref_read(a)};
    end
    case (p)
      0: begin exp_vid.push_back(e); vid_addr = a; vid_req = 1'b1; end
      1: begin exp_cpu.push_back(e); cpu_we = we; cpu_addr = a; cpu_wdata = wd; cpu_req = 1'b1; end
      default: begin exp_ldr.push_back(e); ldr_we = we; ldr_addr = a; ldr_wdata = wd; ldr_req = 1'b1; end
    endcase
    lat = 0;
    welow = 0;
    got = 1'b0;
    while (!got && lat < 60) begin
      @(posedge clk); #1;
      lat++;
      if (!sram_we_n) welow++;
      if (ack_of(p)) got = 1'b1;
    end
    if (!got) begin
      tests++;
      fails++;
      $display("FAIL ack_timeout: port %0d got no ack within %0d clocks, expected one", p, lat);
    end
    case (p)
      0: vid_req = 1'b0;
      1: cpu_req = 1'b0;
      default: ldr_req = 1'b0;
    endcase
    @(posedge clk); #1;
  endtask

  function automatic logic [AW-1:0] rnd_addr(input logic [1:0] region);
    return {region, 17'($urandom)};
  endfunction

  int lat, wl, lat0, lat1, lat2, wl0, wl1, wl2, latv, wlv, latc, wlc, latl, wll;
  int cpu_cnt, guard, n, oh;
  logic vid_done, got4;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1;
    {vid_req, cpu_req, cpu_we, ldr_req, ldr_we} = '0;
    vid_addr = '0; cpu_addr = '0; ldr_addr = '0; cpu_wdata = '0; ldr_wdata = '0;
    {vid_req4, cpu_req4, cpu_we4, ldr_req4, ldr_we4} = '0;
    vid_addr4 = '0; cpu_addr4 = '0; ldr_addr4 = '0; cpu_wdata4 = '0; ldr_wdata4 = '0;
    sram_din4 = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    check("rst_we_n", sram_we_n, 1);
    check("rst_oe", sram_oe, 0);
    check("rst_acks", {vid_ack, cpu_ack, ldr_ack}, 0);
    check("rst_addr", sram_addr, 0);
    check("rst_dout", sram_dout, 0);
    check("rst_rdata", {vid_rdata, cpu_rdata, ldr_rdata}, 0);
    check("rst_we_n_ac4", sram_we_n4, 1);
    rst = 1'b0;
    @(posedge clk); #1;

    // Loader write then read at the top address.
    access(2, 1'b1, 19'h7FFFF, 8'hA5, lat, wl);
    check("t1_wr_lat", lat, 3);
    check("t1_wr_we_low", wl, 1);
    access(2, 1'b0, 19'h7FFFF, 8'h00, lat, wl);
    check("t1_rd_lat", lat, 3);
    check("t1_rd_we_low", wl, 0);
    check("t1_rdata", ldr_rdata, 8'hA5);

    // All three requesters in the same cycle.
    fork
      access(0, 1'b0, rnd_addr(2'b10), 8'h00, lat0, wl0);
      access(1, 1'b1, rnd_addr(2'b00), 8'h3C, lat1, wl1);
      access(2, 1'b0, rnd_addr(2'b01), 8'h00, lat2, wl2);
    join
    check("t2_vid_lat", lat0, 3);
    check("t2_cpu_lat", lat1, 6);
    check("t2_ldr_lat", lat2, 9);

    // CPU and loader back-to-back: grants must alternate.
    ack_log.delete();
    fork
      begin
        for (int k = 0; k < 6; k++)
          access(1, 1'($urandom_range(0, 1)), rnd_addr(2'b00), 8'($urandom), latc, wlc);
      end
      begin
        for (int k = 0; k < 6; k++)
          access(2, 1'($urandom_range(0, 1)), rnd_addr(2'b01), 8'($urandom), latl, wll);
      end
    join
    check("t3_ack_count", ack_log.size(), 12);
    for (int i = 1; i < ack_log.size(); i++)
      check($sformatf("t3_alternate_%0d", i), ack_log[i] != ack_log[i-1], 1);

    // Periodic video against a saturating CPU.
    vid_done = 1'b0;
    cpu_cnt = 0;
    guard = 0;
    fork
      begin
        for (int k = 0; k < 8; k++) begin
          access(0, 1'b0, rnd_addr(2'b10), 8'h00, latv, wlv);
          check($sformatf("t4_vid_lat_le6_%0d", k), latv <= 6, 1);
        end
        vid_done = 1'b1;
      end
      begin
        while (!vid_done && guard < 200) begin
          access(1, 1'($urandom_range(0, 1)), rnd_addr(2'b00), 8'($urandom), latc, wlc);
          cpu_cnt++;
          guard++;
        end
      end
    join
    check("t4_cpu_progress", cpu_cnt >= 3, 1);

    // Random traffic on all ports.
    fork
      begin
        for (int k = 0; k < 25; k++) begin
          repeat ($urandom_range(0, 3)) @(posedge clk);
          #1;
          access(0, 1'b0, rnd_addr(2'b10), 8'h00, latv, wlv);
        end
      end
      begin
        for (int k = 0; k < 25; k++) begin
          repeat ($urandom_range(0, 3)) @(posedge clk);
          #1;
          access(1, 1'($urandom_range(0, 1)), {2'b00, 7'd0, 10'($urandom)}, 8'($urandom), latc, wlc);
        end
      end
      begin
        for (int k = 0; k < 25; k++) begin
          repeat ($urandom_range(0, 3)) @(posedge clk);
          #1;
          access(2, 1'($urandom_range(0, 1)), {2'b01, 7'd0, 10'($urandom)}, 8'($urandom), latl, wll);
        end
      end
    join
    repeat (2) @(posedge clk);
    #1;

    // Reset during the first ACCESS cycle of a CPU write.
    cpu_we = 1'b1; cpu_addr = 19'h00100; cpu_wdata = 8'h5A; cpu_req = 1'b1;
    @(posedge clk); #1;
    check("t5_write_started", sram_we_n, 0);
    rst = 1'b1;
    cpu_req = 1'b0;
    @(posedge clk); #1;
    check("t5_we_n", sram_we_n, 1);
    check("t5_oe", sram_oe, 0);
    check("t5_cpu_ack", cpu_ack, 0);
    check("t5_addr", sram_addr, 0);
    check("t5_rdata", {cpu_rdata, ldr_rdata, vid_rdata}, 0);
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      check("t5_no_ack_after_rst", {vid_ack, cpu_ack, ldr_ack}, 0);
    end
    access(1, 1'b0, 19'h00200, 8'h00, lat, wl);
    check("t5_fresh_read_lat", lat, 3);

    // ACCESS_CYCLES=4 instance: CPU write timing.
    cpu_we4 = 1'b1; cpu_addr4 = 19'h12345; cpu_wdata4 = 8'h3C; cpu_req4 = 1'b1;
    n = 0; wl = 0; oh = 0; got4 = 1'b0;
    while (!got4 && n < 40) begin
      @(posedge clk); #1;
      n++;
      if (!sram_we_n4) wl++;
      if (sram_oe4) oh++;
      if (cpu_ack4) got4 = 1'b1;
    end
    cpu_req4 = 1'b0;
    check("t6_ack_lat", n, 5);
    check("t6_we_low", wl, 3);
    check("t6_oe_high", oh, 4);
    check("t6_addr", sram_addr4, 19'h12345);
    check("t6_dout", sram_dout4, 8'h3C);

    repeat (3) @(posedge clk);
    #1;
    check("end_vid_queue_empty", exp_vid.size(), 0);
    check("end_cpu_queue_empty", exp_cpu.size(), 0);
    check("end_ldr_queue_empty", exp_ldr.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
